// File: rtl/rle_stream_decoder.sv
// rle_stream_decoder
//
// Expands a stream of packed run-length packets arriving on the CPU bus into
// DATA_WIDTH-bit words written to consecutive RAM addresses.
//
// A session starts with two header words: the packet size P and the row count R.
// After that, each bus word carries floor(BUS_WIDTH/P) packets, packed MSB-first.
// A packet is {v, L}. L > 0 appends L copies of v to the fill register. L == 0
// ends a row and flushes any partial word, with its unfilled low bits zero.
//
// Ports
//   CLK, RST        clock; synchronous active-high reset
//   Loading_Enable  level; high = session active, low = abort / return to idle
//   CPU_Bus         input word
//   Bus_Valid       CPU_Bus holds a word
//   Bus_Ready       word is accepted this cycle (registered)
//   RAM_Write       one-cycle write strobe
//   RAM_Address     write address
//   RAM_Data        write data
//   Done_Element    pulse, mirrors RAM_Write
//   Done_Row        pulse per consumed row terminator
//   Done_Loading    level; all R rows decoded
//   Format_Error    level; illegal packet size in the header
module rle_stream_decoder #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64,
    parameter int BUS_WIDTH     = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Loading_Enable,
    input  logic [BUS_WIDTH-1:0]     CPU_Bus,
    input  logic                     Bus_Valid,
    output logic                     Bus_Ready,
    output logic                     RAM_Write,
    output logic [ADDRESS_WIDTH-1:0] RAM_Address,
    output logic [DATA_WIDTH-1:0]    RAM_Data,
    output logic                     Done_Element,
    output logic                     Done_Row,
    output logic                     Done_Loading,
    output logic                     Format_Error
);

    localparam int FW = $clog2(DATA_WIDTH) + 1;
    localparam int OW = $clog2(BUS_WIDTH) + 2;
    localparam int CW = ((BUS_WIDTH > FW) ? BUS_WIDTH : FW) + 1;
    localparam logic [DATA_WIDTH-1:0] ONES = '1;

    typedef enum logic [2:0] {IDLE, HDR_SIZE, HDR_ROWS, DECODE, DONE, ERROR} state_t;

    state_t                   state;
    logic [5:0]               pkt_size;
    logic [15:0]              row_total;
    logic [15:0]              row_cnt;
    logic [BUS_WIDTH-1:0]     buf_word;
    logic                     buf_full;
    logic [OW-1:0]            lane_off;   // bit offset of the current lane from the MSB
    logic                     run_cont;   // a run is still being emitted across words
    logic                     run_val;
    logic [BUS_WIDTH-1:0]     run_rem;
    logic [DATA_WIDTH-1:0]    fill;
    logic [FW-1:0]            fill_cnt;
    logic [ADDRESS_WIDTH-1:0] wr_addr;

    // Current packet decode
    logic [BUS_WIDTH-1:0]  lane_bits;
    logic [BUS_WIDTH-1:0]  len_mask;
    logic [BUS_WIDTH-1:0]  pkt_len;
    logic [BUS_WIDTH-1:0]  cur_len;
    logic                  cur_val;
    logic                  is_term;
    logic                  last_lane;
    logic [FW-1:0]         space;
    logic                  completes;
    logic [BUS_WIDTH-1:0]  rem_next;
    logic [DATA_WIDTH-1:0] word_out;
    logic [DATA_WIDTH-1:0] fill_add;

    always_comb begin
        lane_bits = buf_word << lane_off;
        len_mask  = {BUS_WIDTH{1'b1}} >> (32'(BUS_WIDTH) + 32'd1 - 32'(pkt_size));
        pkt_len   = (lane_bits >> (32'(BUS_WIDTH) - 32'(pkt_size))) & len_mask;
        cur_val   = run_cont ? run_val : lane_bits[BUS_WIDTH-1];
        cur_len   = run_cont ? run_rem : pkt_len;
        is_term   = !run_cont && (pkt_len == '0);
        // No further whole packet fits after this lane
        last_lane = (32'(lane_off) + 32'(pkt_size) + 32'(pkt_size)) > 32'(BUS_WIDTH);
        space     = FW'(DATA_WIDTH) - fill_cnt;
        completes = CW'(cur_len) >= CW'(space);
        rem_next  = BUS_WIDTH'(CW'(cur_len) - CW'(space));
        word_out  = fill | (cur_val ? (ONES >> fill_cnt) : '0);
        fill_add  = cur_val ? ((ONES >> fill_cnt) & ~(ONES >> (CW'(fill_cnt) + CW'(cur_len)))) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            pkt_size     <= '0;
            row_total    <= '0;
            row_cnt      <= '0;
            buf_word     <= '0;
            buf_full     <= 1'b0;
            lane_off     <= '0;
            run_cont     <= 1'b0;
            run_val      <= 1'b0;
            run_rem      <= '0;
            fill         <= '0;
            fill_cnt     <= '0;
            wr_addr      <= '0;
            Bus_Ready    <= 1'b0;
            RAM_Write    <= 1'b0;
            RAM_Address  <= '0;
            RAM_Data     <= '0;
            Done_Element <= 1'b0;
            Done_Row     <= 1'b0;
            Done_Loading <= 1'b0;
            Format_Error <= 1'b0;
        end else begin
            RAM_Write    <= 1'b0;
            Done_Element <= 1'b0;
            Done_Row     <= 1'b0;
            if (!Loading_Enable) begin
                // Abort or end of session: drop everything, next session starts at address 0
                state        <= IDLE;
                Bus_Ready    <= 1'b0;
                Done_Loading <= 1'b0;
                Format_Error <= 1'b0;
                RAM_Address  <= '0;
                RAM_Data     <= '0;
                buf_full     <= 1'b0;
                lane_off     <= '0;
                run_cont     <= 1'b0;
                fill         <= '0;
                fill_cnt     <= '0;
                row_cnt      <= '0;
                wr_addr      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= HDR_SIZE;
                        Bus_Ready <= 1'b1;
                    end
                    HDR_SIZE: begin
                        if (Bus_Valid) begin
                            pkt_size <= CPU_Bus[5:0];
                            if (CPU_Bus[5:0] < 6'd2 || 32'(CPU_Bus[5:0]) > 32'(BUS_WIDTH)) begin
                                state        <= ERROR;
                                Format_Error <= 1'b1;
                                Bus_Ready    <= 1'b0;
                            end else begin
                                state <= HDR_ROWS;
                            end
                        end
                    end
                    HDR_ROWS: begin
                        if (Bus_Valid) begin
                            row_total <= CPU_Bus[15:0];
                            if (CPU_Bus[15:0] == 16'd0) begin
                                state        <= DONE;
                                Done_Loading <= 1'b1;
                                Bus_Ready    <= 1'b0;
                            end else begin
                                state <= DECODE;
                            end
                        end
                    end
                    DECODE: begin
                        if (!buf_full) begin
                            if (Bus_Ready && Bus_Valid) begin
                                buf_word  <= CPU_Bus;
                                buf_full  <= 1'b1;
                                lane_off  <= '0;
                                Bus_Ready <= 1'b0;
                            end
                        end else begin
                            if (is_term) begin
                                if (fill_cnt != '0) begin
                                    RAM_Write    <= 1'b1;
                                    Done_Element <= 1'b1;
                                    RAM_Address  <= wr_addr;
                                    RAM_Data     <= fill;
                                    wr_addr      <= wr_addr + ADDRESS_WIDTH'(1);
                                end
                                fill     <= '0;
                                fill_cnt <= '0;
                                Done_Row <= 1'b1;
                                row_cnt  <= row_cnt + 16'd1;
                            end else if (completes) begin
                                RAM_Write    <= 1'b1;
                                Done_Element <= 1'b1;
                                RAM_Address  <= wr_addr;
                                RAM_Data     <= word_out;
                                wr_addr      <= wr_addr + ADDRESS_WIDTH'(1);
                                fill         <= '0;
                                fill_cnt     <= '0;
                                run_val      <= cur_val;
                                run_rem      <= rem_next;
                                run_cont     <= (rem_next != '0);
                            end else begin
                                fill     <= fill | fill_add;
                                fill_cnt <= fill_cnt + FW'(cur_len);
                                run_cont <= 1'b0;
                            end

                            if (is_term && (row_cnt + 16'd1 == row_total)) begin
                                // Last row: any remaining lanes are discarded
                                state        <= DONE;
                                Done_Loading <= 1'b1;
                                buf_full     <= 1'b0;
                                Bus_Ready    <= 1'b0;
                            end else if (!(completes && !is_term && rem_next != '0)) begin
                                // Advance unless a run is still spilling into the next word
                                if (last_lane) begin
                                    buf_full  <= 1'b0;
                                    lane_off  <= '0;
                                    Bus_Ready <= 1'b1;
                                end else begin
                                    lane_off <= lane_off + OW'(pkt_size);
                                end
                            end
                        end
                    end
                    DONE: begin
                        Bus_Ready <= 1'b0;
                    end
                    ERROR: begin
                        Bus_Ready <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rle_stream_decoder.sv
`timescale 1ns/1ps
module tb_rle_stream_decoder;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int BW = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          Loading_Enable = 1'b0;
    logic [BW-1:0] CPU_Bus = '0;
    logic          Bus_Valid = 1'b0;
    logic          Bus_Ready;
    logic          RAM_Write;
    logic [AW-1:0] RAM_Address;
    logic [DW-1:0] RAM_Data;
    logic          Done_Element;
    logic          Done_Row;
    logic          Done_Loading;
    logic          Format_Error;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] wdata[$];
    logic [AW-1:0] waddr[$];
    int            rows_seen = 0;

    always #5 CLK = ~CLK;

    rle_stream_decoder #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .BUS_WIDTH    (BW)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Loading_Enable(Loading_Enable),
        .CPU_Bus     (CPU_Bus),
        .Bus_Valid   (Bus_Valid),
        .Bus_Ready   (Bus_Ready),
        .RAM_Write   (RAM_Write),
        .RAM_Address (RAM_Address),
        .RAM_Data    (RAM_Data),
        .Done_Element(Done_Element),
        .Done_Row    (Done_Row),
        .Done_Loading(Done_Loading),
        .Format_Error(Format_Error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Capture writes and row pulses away from the active edge
    always @(negedge CLK) begin
        if (RAM_Write) begin
            wdata.push_back(RAM_Data);
            waddr.push_back(RAM_Address);
        end
        if (Done_Row) rows_seen++;
        if (RAM_Write || Done_Element) chk("done_element", 64'(Done_Element), 64'(RAM_Write));
    end

    function automatic logic [63:0] wd(input int i);
        return (i < wdata.size()) ? wdata[i] : 64'hDEAD_BEEF_DEAD_BEEF;
    endfunction

    function automatic logic [63:0] wa(input int i);
        return (i < waddr.size()) ? 64'(waddr[i]) : 64'hFFFF;
    endfunction

    // Offer one word; with gaps, Bus_Valid is randomly withheld per cycle
    task automatic send(input logic [BW-1:0] w, input bit gaps);
        int n;
        bit accepted;
        n = 0;
        accepted = 1'b0;
        CPU_Bus = w;
        while (!accepted && n < 100) begin
            Bus_Valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge CLK);
            accepted = Bus_Valid && Bus_Ready;
            @(posedge CLK);
            #1;
            n++;
        end
        chk("send_accept", 64'(accepted), 64'd1);
        Bus_Valid = 1'b0;
        CPU_Bus = $urandom;
    endtask

    task automatic wait_done(input string tag, output logic dr, output logic rw);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!Done_Loading && n < 200);
        chk(tag, 64'(Done_Loading), 64'd1);
        dr = Done_Row;
        rw = RAM_Write;
        @(posedge CLK);
        #1;
    endtask

    task automatic end_session();
        Loading_Enable = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        wdata.delete();
        waddr.delete();
        rows_seen = 0;
    endtask

    task automatic wait_write(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!RAM_Write && n < 50);
        chk(tag, 64'(RAM_Write), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic dr;
        logic rw;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_bus_ready",    64'(Bus_Ready),    64'd0);
        chk("rst_ram_write",    64'(RAM_Write),    64'd0);
        chk("rst_ram_address",  64'(RAM_Address),  64'd0);
        chk("rst_ram_data",     64'(RAM_Data),     64'd0);
        chk("rst_done_row",     64'(Done_Row),     64'd0);
        chk("rst_done_loading", 64'(Done_Loading), 64'd0);
        chk("rst_format_error", 64'(Format_Error), 64'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        chk("idle_ready", 64'(Bus_Ready), 64'd0);

        // Single full word, with Bus_Ready latency out of IDLE
        Loading_Enable = 1'b1;
        @(negedge CLK);
        chk("ready_pre", 64'(Bus_Ready), 64'd0);
        @(negedge CLK);
        chk("ready_rise", 64'(Bus_Ready), 64'd1);
        @(posedge CLK);
        #1;
        send(32'd8, 1'b0);
        send(32'd1, 1'b0);
        send(32'hC000_0000, 1'b0);
        wait_done("t1_done", dr, rw);
        chk("t1_done_row_same_cycle", 64'(dr), 64'd1);
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        chk("t1_writes", 64'(wdata.size()), 64'd1);
        chk("t1_data0",  wd(0), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_addr0",  wa(0), 64'd0);
        chk("t1_rows",   64'(rows_seen), 64'd1);
        chk("t1_loading_level", 64'(Done_Loading), 64'd1);
        chk("t1_ready_in_done", 64'(Bus_Ready), 64'd0);
        end_session();
        chk("t1_loading_cleared", 64'(Done_Loading), 64'd0);

        // Run spanning two output words; final terminator with F=0 writes nothing
        Loading_Enable = 1'b1;
        send(32'd8, 1'b0);
        send(32'd1, 1'b0);
        send(32'h649C_0000, 1'b0);
        wait_done("t2_done", dr, rw);
        chk("t2_no_final_write", 64'(rw), 64'd0);
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        chk("t2_writes", 64'(wdata.size()), 64'd2);
        chk("t2_data0",  wd(0), 64'h0);
        chk("t2_data1",  wd(1), 64'h0000_0000_0FFF_FFFF);
        chk("t2_addr1",  wa(1), 64'd1);
        chk("t2_rows",   64'(rows_seen), 64'd1);
        end_session();

        // Padding write, then an empty row
        Loading_Enable = 1'b1;
        send(32'd8, 1'b0);
        send(32'd2, 1'b0);
        send(32'h8300_0000, 1'b0);
        wait_done("t3_done", dr, rw);
        chk("t3_done_row_same_cycle", 64'(dr), 64'd1);
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        chk("t3_writes", 64'(wdata.size()), 64'd1);
        chk("t3_data0",  wd(0), 64'hE000_0000_0000_0000);
        chk("t3_rows",   64'(rows_seen), 64'd2);
        end_session();

        // Largest legal packet size: one lane per word
        Loading_Enable = 1'b1;
        send(32'd32, 1'b0);
        send(32'd1, 1'b0);
        send(32'h8000_0040, 1'b0);
        send(32'h0000_0000, 1'b0);
        wait_done("t4_done", dr, rw);
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        chk("t4_writes", 64'(wdata.size()), 64'd1);
        chk("t4_data0",  wd(0), 64'hFFFF_FFFF_FFFF_FFFF);
        end_session();

        // Format errors: P=1 and P=33
        Loading_Enable = 1'b1;
        send(32'd1, 1'b0);
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        chk("err1_flag",   64'(Format_Error), 64'd1);
        chk("err1_ready",  64'(Bus_Ready),    64'd0);
        chk("err1_writes", 64'(wdata.size()), 64'd0);
        end_session();
        chk("err1_cleared", 64'(Format_Error), 64'd0);
        Loading_Enable = 1'b1;
        send(32'd33, 1'b0);
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        chk("err33_flag",  64'(Format_Error), 64'd1);
        chk("err33_ready", 64'(Bus_Ready),    64'd0);
        end_session();
        chk("err33_cleared", 64'(Format_Error), 64'd0);

        // P=5 (six lanes, low two bits ignored), gap-free then with random gaps
        for (int pass = 0; pass < 2; pass++) begin
            Loading_Enable = 1'b1;
            send(32'd5, pass[0]);
            send(32'd2, pass[0]);
            send(32'hFBFE_FA4F, pass[0]);
            send(32'h07FE_287D, pass[0]);
            wait_done("p5_done", dr, rw);
            chk("p5_final_pad_write", 64'(rw), 64'd1);
            chk("p5_final_done_row",  64'(dr), 64'd1);
            repeat (2) begin
                @(posedge CLK);
                #1;
            end
            chk("p5_writes", 64'(wdata.size()), 64'd3);
            chk("p5_data0",  wd(0), 64'hFFFE_0003_FFF8_000F);
            chk("p5_data1",  wd(1), 64'hE000_0000_0000_0000);
            chk("p5_data2",  wd(2), 64'hFFFF_FFFC_0000_0000);
            chk("p5_addr2",  wa(2), 64'd2);
            chk("p5_rows",   64'(rows_seen), 64'd2);
            end_session();
        end

        // Abort via Loading_Enable during a 200-bit run
        Loading_Enable = 1'b1;
        send(32'd16, 1'b0);
        send(32'd1, 1'b0);
        send(32'h80C8_0000, 1'b0);
        wait_write("abort_first_write");
        Loading_Enable = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        chk("abort_writes",  64'(wdata.size()), 64'd1);
        chk("abort_addr0",   wa(0), 64'd0);
        chk("abort_ram_write", 64'(RAM_Write),   64'd0);
        chk("abort_ram_addr",  64'(RAM_Address), 64'd0);
        chk("abort_ram_data",  64'(RAM_Data),    64'd0);
        chk("abort_ready",     64'(Bus_Ready),   64'd0);
        end_session();
        Loading_Enable = 1'b1;
        send(32'd8, 1'b0);
        send(32'd1, 1'b0);
        send(32'hC000_0000, 1'b0);
        wait_done("post_abort_done", dr, rw);
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        chk("post_abort_addr0", wa(0), 64'd0);
        chk("post_abort_data0", wd(0), 64'hFFFF_FFFF_FFFF_FFFF);
        end_session();

        // Reset pulse during a 200-bit run, Loading_Enable still high
        Loading_Enable = 1'b1;
        send(32'd16, 1'b0);
        send(32'd1, 1'b0);
        send(32'h80C8_0000, 1'b0);
        wait_write("rst_mid_first_write");
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_mid_ram_write", 64'(RAM_Write),    64'd0);
        chk("rst_mid_ram_addr",  64'(RAM_Address),  64'd0);
        chk("rst_mid_ram_data",  64'(RAM_Data),     64'd0);
        chk("rst_mid_ready",     64'(Bus_Ready),    64'd0);
        chk("rst_mid_loading",   64'(Done_Loading), 64'd0);
        RST = 1'b0;
        Loading_Enable = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        chk("rst_mid_writes", 64'(wdata.size()), 64'd1);
        end_session();
        Loading_Enable = 1'b1;
        send(32'd8, 1'b0);
        send(32'd1, 1'b0);
        send(32'hC000_0000, 1'b0);
        wait_done("post_rst_done", dr, rw);
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        chk("post_rst_writes", 64'(wdata.size()), 64'd1);
        chk("post_rst_addr0",  wa(0), 64'd0);
        end_session();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
